// File: rtl/uart_baud_gen.sv
// Baud tick generator: oversample, mid-bit and bit strobes plus a square baud clock.
// Define BAUD_GEN_FRAC_EN to build the fractional divisor accumulator.
module uart_baud_gen #(
   parameter int SYSTEM_CLK_FREQ = 125_000_000,
   parameter int DEFAULT_BAUD    = 9600,
   parameter int OVERSAMPLE      = 16,
   parameter int DIV_W           = 16,
   parameter int FRAC_W          = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_restart,
   input  logic              i_div_load,
   input  logic [DIV_W-1:0]  i_div_int,
   input  logic [FRAC_W-1:0] i_div_frac,
   output logic              o_os_tick,
   output logic              o_mid_tick,
   output logic              o_bit_tick,
   output logic              o_baud_clk
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [63:0] DX =
      (64'(SYSTEM_CLK_FREQ) << FRAC_W) / (64'(OVERSAMPLE) * 64'(DEFAULT_BAUD));
   localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(DX >> FRAC_W);
   localparam logic [DIV_W:0]   CNT_DEF = (DIV_W+1)'(DEF_INT) - (DIV_W+1)'(1);
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_PREMID = OS_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_W-1:0] r_act_int;
   logic [DIV_W-1:0] r_pend_int;
   logic             r_pend_vld;
   logic [DIV_W:0]   r_cnt;
   logic [OS_W-1:0]  r_os_cnt;

   logic [DIV_W-1:0] w_load_int;
   logic [DIV_W-1:0] w_next_int;
   logic             w_reload;
   logic             w_carry;
   logic [DIV_W:0]   w_cnt_reload;
   logic [DIV_W:0]   w_cnt_restart;

   assign w_load_int = (i_div_int < DIV_W'(2)) ? DIV_W'(2) : i_div_int;
   assign w_reload   = i_en && (r_cnt == '0);

   // A restart applies a same-cycle load directly, otherwise whatever is pending.
   assign w_next_int = (i_restart && i_div_load) ? w_load_int :
                       r_pend_vld ? r_pend_int : r_act_int;

   assign w_cnt_restart = (DIV_W+1)'(w_next_int) - (DIV_W+1)'(1);
   assign w_cnt_reload  = w_cnt_restart + (DIV_W+1)'(w_carry);

`ifdef BAUD_GEN_FRAC_EN
   localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DX);

   logic [FRAC_W-1:0] r_act_frac;
   logic [FRAC_W-1:0] r_pend_frac;
   logic [FRAC_W-1:0] r_frac_acc;
   logic [FRAC_W-1:0] w_next_frac;
   logic [FRAC_W-1:0] w_frac_sum;

   assign w_next_frac = (i_restart && i_div_load) ? i_div_frac :
                        r_pend_vld ? r_pend_frac : r_act_frac;
   assign {w_carry, w_frac_sum} = {1'b0, r_frac_acc} + {1'b0, w_next_frac};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_act_frac  <= DEF_FRAC;
         r_pend_frac <= '0;
         r_frac_acc  <= '0;
      end else begin
         if (i_div_load) r_pend_frac <= i_div_frac;
         if (i_restart) begin
            r_act_frac <= w_next_frac;
            r_frac_acc <= '0;
         end else if (w_reload) begin
            r_act_frac <= w_next_frac;
            r_frac_acc <= w_frac_sum;
         end
      end
   end
`else
   logic w_unused_frac;
   assign w_unused_frac = ^i_div_frac;
   assign w_carry       = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_act_int  <= DEF_INT;
         r_pend_int <= DEF_INT;
         r_pend_vld <= 1'b0;
         r_cnt      <= CNT_DEF;
         r_os_cnt   <= '0;
         o_os_tick  <= 1'b0;
         o_mid_tick <= 1'b0;
         o_bit_tick <= 1'b0;
         o_baud_clk <= 1'b0;
      end else begin
         o_os_tick  <= 1'b0;
         o_mid_tick <= 1'b0;
         o_bit_tick <= 1'b0;

         if (i_div_load) r_pend_int <= w_load_int;
         if (i_restart)       r_pend_vld <= 1'b0;
         else if (i_div_load) r_pend_vld <= 1'b1;
         else if (w_reload)   r_pend_vld <= 1'b0;

         if (i_restart) begin
            r_act_int  <= w_next_int;
            r_cnt      <= w_cnt_restart;
            r_os_cnt   <= '0;
            o_baud_clk <= 1'b0;
         end else if (w_reload) begin
            r_act_int <= w_next_int;
            r_cnt     <= w_cnt_reload;
            o_os_tick <= 1'b1;
            r_os_cnt  <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
            if (r_os_cnt == OS_LAST) begin
               o_bit_tick <= 1'b1;
               o_baud_clk <= 1'b0;
            end
            if (r_os_cnt == OS_PREMID) begin
               o_mid_tick <= 1'b1;
               o_baud_clk <= 1'b1;
            end
         end else if (i_en) begin
            r_cnt <= r_cnt - (DIV_W+1)'(1);
         end
      end
   end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud tick generator for the UART, the successor of the fixed-divide baud clock. It produces one-cycle oversample, mid-bit and bit strobes plus a square baud clock from the system clock. The divisor is runtime-programmable with an optional fractional part. A restart input lets the RX path re-phase the generator on a detected start edge.

## Interface
- SYSTEM_CLK_FREQ, 125_000_000: system clock frequency in Hz.
- DEFAULT_BAUD, 9600: baud rate loaded at reset.
- OVERSAMPLE, 16: oversample ticks per bit; must be even and at least 4.
- DIV_W, 16: width of the integer divisor.
- FRAC_W, 4: width of the fractional divisor.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; when low, all counters hold.
- restart  input  1  one-cycle phase realign request.
- div_load  input  1  one-cycle strobe that captures div_int and div_frac.
- div_int  input  DIV_W  integer clk cycles per oversample tick.
- div_frac  input  FRAC_W  fractional cycles per tick, in units of 1/2^FRAC_W.
- os_tick  output  1  one-cycle pulse at OVERSAMPLE × baud.
- mid_tick  output  1  one-cycle pulse at the bit centre.
- bit_tick  output  1  one-cycle pulse at the bit boundary.
- baud_clk  output  1  square wave at the baud rate.

## Operation
- Default divisor, fixed at elaboration: DX = floor(SYSTEM_CLK_FREQ·2^FRAC_W / (OVERSAMPLE·DEFAULT_BAUD)).
  - int = DX >> FRAC_W, frac = DX mod 2^FRAC_W.
  - With all defaults: int 813, frac 12.
- State: active divisor registers act_int and act_frac; pending registers pend_int, pend_frac and a pend_vld flag; cycle counter cnt (DIV_W+1 bits); frac_acc (FRAC_W bits); os_cnt (log2 OVERSAMPLE bits).
- Reset values:
  - cnt = default int − 1; frac_acc = 0; os_cnt = 0; pend_vld = 0; act = default.
  - Outputs os_tick, mid_tick, bit_tick and baud_clk are all 0.
- div_load: captures the inputs into the pending registers and sets pend_vld. An act_int below 2 is clamped to 2.
- Reload event, when en=1 and cnt==0:
  - If pend_vld is set, pending is copied into active and pend_vld clears.
  - {carry, frac_acc} = frac_acc + act_frac.
  - cnt = act_int − 1 + carry. The act values used here are the ones after the pending copy.
  - os_tick=1 next cycle; os_cnt increments modulo OVERSAMPLE.
- Otherwise, when en=1, cnt decrements. When en=0, all state holds and the tick outputs are 0.
- bit_tick: asserted with the os_tick whose increment wraps os_cnt from OVERSAMPLE−1 to 0.
- mid_tick: asserted with the os_tick that moves os_cnt to OVERSAMPLE/2.
- baud_clk: set to 1 on the mid_tick event and to 0 on the bit_tick event.
- restart, which acts even when en=0:
  - Next cycle: cnt = act_int − 1, frac_acc = 0, os_cnt = 0, baud_clk = 0, and no tick is issued that cycle.
  - A pending divisor is applied immediately.
  - restart has priority over a reload that falls in the same cycle.
- div_load and restart in the same cycle: the new divisor is captured and applied by the restart.
- Reset mid-operation: all state returns to its reset values asynchronously, and the loaded divisor is lost.

## Timing
- All outputs are registered. Each tick is high for exactly one clk cycle.
- With en held high after reset release, the first os_tick is high in the cycle after the default-int-th rising edge.
- Tick spacing is act_int cycles, or act_int+1 when the fractional accumulator carries.
- Bit period over OVERSAMPLE ticks = OVERSAMPLE·act_int + floor(OVERSAMPLE·act_frac / 2^FRAC_W) cycles, exactly, starting from frac_acc=0.
- After restart, the first os_tick arrives act_int cycles later and the first bit_tick OVERSAMPLE ticks later.
- A divisor change never shortens or splits the tick period in progress.

## Configuration
- BAUD_GEN_FRAC_EN defined: the fractional accumulator is present and behaves as described above.
- BAUD_GEN_FRAC_EN undefined:
  - div_frac is ignored, and frac_acc and pend_frac are not built.
  - carry is always 0 and every tick period is exactly act_int cycles.
  - The default divisor is the int part only (813 with default parameters).

## Test plan
- Reset with defaults and en=1 -> os_tick every 813 or 814 cycles; bit_tick every 16 os_ticks; first bit period 13020 cycles; baud_clk rises at os tick 8 and falls at tick 16.
- div_load with int 67, frac 13 (115200 baud) -> after the current period completes, each bit period is 1085 cycles, and exactly 13 of the 16 os intervals are 68 cycles.
- en held low for 500 cycles mid-period -> no ticks; the period resumes with the same remaining count, so the tick is delayed by exactly 500 cycles.
- restart at os_cnt=11 -> os_tick after act_int cycles, mid_tick on the 8th tick after restart, bit_tick on the 16th; baud_clk is 0 the cycle after restart.
- div_int=1 loaded -> behaves as div_int=2, with os_tick every 2 cycles (frac 0).
- rst asserted during an active bit -> all outputs 0 asynchronously; after release the 813-cycle default timing resumes.
